// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - button-driven hour/min/sec edit FSM with timed overwrite strobe
// Captures the running time, edits one field at a time, then strobes it back into the clock.
module clock_set_ctrl #(
  parameter int OW_CYCLES   = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [16:0] time_cur,
  output logic [16:0] time_in,
  output logic        time_ow,
  output logic        editing,
  output logic [1:0]  edit_field
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HR,
    EDIT_MIN,
    EDIT_SEC,
    COMMIT
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] time_nxt;
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic [7:0]  ow_cnt, ow_nxt;

  logic [5:0]  fld, fld_max, fld_new;
  logic [16:0] time_edit;
  logic        adj;

  // Out-of-range captured values wrap like the max: inc goes to 0, dec goes to max.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] mx);
    return (v >= mx) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] mx);
    return (v == 6'd0 || v > mx) ? mx : v - 6'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      time_in <= '0;
      to_cnt  <= '0;
      ow_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      time_in <= time_nxt;
      to_cnt  <= to_nxt;
      ow_cnt  <= ow_nxt;
    end
  end

  always_comb begin
    fld     = time_in[5:0];
    fld_max = 6'd59;
    case (state)
      EDIT_HR:  begin fld = {1'b0, time_in[16:12]}; fld_max = 6'd23; end
      EDIT_MIN: fld = time_in[11:6];
      default:  fld = time_in[5:0];
    endcase
    fld_new   = btn_inc ? wrap_inc(fld, fld_max) : wrap_dec(fld, fld_max);
    time_edit = time_in;
    case (state)
      EDIT_HR:  time_edit[16:12] = fld_new[4:0];
      EDIT_MIN: time_edit[11:6]  = fld_new;
      default:  time_edit[5:0]   = fld_new;
    endcase
    adj = btn_inc ^ btn_dec;
  end

  always_comb begin
    state_nxt  = state;
    time_nxt   = time_in;
    to_nxt     = to_cnt;
    ow_nxt     = ow_cnt;
    time_ow    = 1'b0;
    editing    = 1'b0;
    edit_field = 2'd0;
    case (state)
      IDLE: begin
        if (btn_mode) begin
          state_nxt = EDIT_HR;
          time_nxt  = time_cur;
          to_nxt    = '0;
        end
      end
      EDIT_HR, EDIT_MIN, EDIT_SEC: begin
        editing    = 1'b1;
        edit_field = (state == EDIT_HR) ? 2'd1 : (state == EDIT_MIN) ? 2'd2 : 2'd3;
        if (btn_mode) begin
          state_nxt = (state == EDIT_HR) ? EDIT_MIN : (state == EDIT_MIN) ? EDIT_SEC : COMMIT;
          to_nxt    = '0;
          ow_nxt    = '0;
        end else if (adj) begin
          time_nxt = time_edit;
          to_nxt   = '0;
        end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = IDLE;
          to_nxt    = '0;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      COMMIT: begin
        time_ow = 1'b1;
        if (ow_cnt == 8'(OW_CYCLES - 1)) begin
          state_nxt = IDLE;
          ow_nxt    = '0;
        end else begin
          ow_nxt = ow_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
// Committed values go through a scoreboard queue checked on each time_ow rising edge.
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [16:0] time_cur = '0;
  logic [16:0] time_in;
  logic        time_ow, editing;
  logic [1:0]  edit_field;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb[$];
  logic        ow_prev = 1'b0;

  clock_set_ctrl #(.OW_CYCLES(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .time_cur(time_cur), .time_in(time_in), .time_ow(time_ow), .editing(editing),
    .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] hms(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    return {h, m, s};
  endfunction

  // Scoreboard: every time_ow rising edge must match the oldest expected commit.
  always @(negedge clk) begin
    if (time_ow && !ow_prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: time_ow rose with time_in=%h, none expected", time_in);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        if (time_in !== e) begin
          errors++;
          $display("FAIL commit_value: got %h expected %h", time_in, e);
        end
      end
    end
    ow_prev = time_ow;
  end

  task automatic pulse(input logic m, input logic i, input logic d);
    @(negedge clk);
    btn_mode = m; btn_inc = i; btn_dec = d;
    @(negedge clk);
    btn_mode = 0; btn_inc = 0; btn_dec = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    time_cur = hms(5'd3, 6'd4, 6'd5);
    #12;
    checks++;
    if ({time_in, time_ow, editing, edit_field} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b/%d expected 0/0/0/0", time_in, time_ow, editing, edit_field);
    end
    @(negedge clk);
    rst_n = 1; btn_mode = 1;
    @(negedge clk);
    btn_mode = 0;
    checks++;
    if (editing !== 1'b1 || edit_field !== 2'd1 || time_in !== hms(5'd3, 6'd4, 6'd5)) begin
      errors++;
      $display("FAIL first_mode_after_reset: got ed=%b fld=%d t=%h expected 1/1/%h", editing, edit_field, time_in, hms(5'd3, 6'd4, 6'd5));
    end
  endtask

  task automatic test_full_set();
    int ow_n;
    logic [16:0] e;
    do_reset();
    time_cur = hms(5'd12, 6'd34, 6'd56);
    pulse(1, 0, 0);
    checks++;
    if (time_in !== hms(5'd12, 6'd34, 6'd56) || edit_field !== 2'd1) begin
      errors++;
      $display("FAIL capture: got %h fld=%d expected %h fld=1", time_in, edit_field, hms(5'd12, 6'd34, 6'd56));
    end
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    checks++;
    if (time_in !== hms(5'd14, 6'd34, 6'd56) || edit_field !== 2'd2) begin
      errors++;
      $display("FAIL hour_inc: got %h fld=%d expected %h fld=2", time_in, edit_field, hms(5'd14, 6'd34, 6'd56));
    end
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    e = hms(5'd14, 6'd33, 6'd56);
    checks++;
    if (time_in !== e || edit_field !== 2'd3 || time_ow !== 1'b0) begin
      errors++;
      $display("FAIL min_dec: got %h fld=%d ow=%b expected %h fld=3 ow=0", time_in, edit_field, time_ow, e);
    end
    sb.push_back(e);
    pulse(1, 0, 0);
    checks++;
    if (time_ow !== 1'b1 || editing !== 1'b0 || edit_field !== 2'd0) begin
      errors++;
      $display("FAIL commit_entry: got ow=%b ed=%b fld=%d expected 1/0/0", time_ow, editing, edit_field);
    end
    ow_n = 0;
    for (int k = 0; k < 6; k++) begin
      if (time_ow) ow_n++;
      checks++;
      if (time_in !== e) begin
        errors++;
        $display("FAIL commit_stable: cycle %0d got %h expected %h", k, time_in, e);
      end
      @(negedge clk);
    end
    checks++;
    if (ow_n != 2 || editing !== 1'b0 || edit_field !== 2'd0) begin
      errors++;
      $display("FAIL commit_length: got %0d ow cycles ed=%b fld=%d expected 2/0/0", ow_n, editing, edit_field);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    time_cur = hms(5'd23, 6'd0, 6'd59);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    checks++;
    if (time_in !== hms(5'd0, 6'd0, 6'd59)) begin
      errors++;
      $display("FAIL hour_wrap_inc: got %h expected %h", time_in, hms(5'd0, 6'd0, 6'd59));
    end
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    checks++;
    if (time_in !== hms(5'd0, 6'd59, 6'd59)) begin
      errors++;
      $display("FAIL min_wrap_dec: got %h expected %h", time_in, hms(5'd0, 6'd59, 6'd59));
    end
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    checks++;
    if (time_in !== hms(5'd0, 6'd59, 6'd0)) begin
      errors++;
      $display("FAIL sec_wrap_inc: got %h expected %h", time_in, hms(5'd0, 6'd59, 6'd0));
    end
    do_reset();
    time_cur = hms(5'd30, 6'd10, 6'd10);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    checks++;
    if (time_in !== hms(5'd0, 6'd10, 6'd10)) begin
      errors++;
      $display("FAIL hour30_inc: got %h expected %h", time_in, hms(5'd0, 6'd10, 6'd10));
    end
    do_reset();
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    checks++;
    if (time_in !== hms(5'd23, 6'd10, 6'd10)) begin
      errors++;
      $display("FAIL hour30_dec: got %h expected %h", time_in, hms(5'd23, 6'd10, 6'd10));
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    time_cur = hms(5'd1, 6'd2, 6'd3);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 1, 0);
    checks++;
    if (edit_field !== 2'd3 || time_in !== hms(5'd1, 6'd2, 6'd3)) begin
      errors++;
      $display("FAIL mode_over_inc: got fld=%d t=%h expected fld=3 t=%h", edit_field, time_in, hms(5'd1, 6'd2, 6'd3));
    end
    pulse(0, 1, 1);
    checks++;
    if (edit_field !== 2'd3 || time_in !== hms(5'd1, 6'd2, 6'd3)) begin
      errors++;
      $display("FAIL inc_dec_ignored: got fld=%d t=%h expected fld=3 t=%h", edit_field, time_in, hms(5'd1, 6'd2, 6'd3));
    end
  endtask

  task automatic test_ignored();
    logic [16:0] e;
    do_reset();
    time_cur = hms(5'd7, 6'd8, 6'd9);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    checks++;
    if (editing !== 1'b0 || time_in !== 17'd0 || time_ow !== 1'b0) begin
      errors++;
      $display("FAIL idle_inc_dec: got ed=%b t=%h ow=%b expected 0/0/0", editing, time_in, time_ow);
    end
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    e = hms(5'd8, 6'd8, 6'd9);
    sb.push_back(e);
    pulse(1, 0, 0);
    btn_mode = 1; btn_inc = 1;
    @(negedge clk);
    btn_mode = 1; btn_inc = 0; btn_dec = 1;
    checks++;
    if (time_ow !== 1'b1 || editing !== 1'b0 || time_in !== e) begin
      errors++;
      $display("FAIL commit_buttons_c2: got ow=%b ed=%b t=%h expected 1/0/%h", time_ow, editing, time_in, e);
    end
    @(negedge clk);
    btn_mode = 0; btn_dec = 0;
    checks++;
    if (time_ow !== 1'b0 || editing !== 1'b0 || time_in !== e) begin
      errors++;
      $display("FAIL commit_buttons_end: got ow=%b ed=%b t=%h expected 0/0/%h", time_ow, editing, time_in, e);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    time_cur = hms(5'd5, 6'd6, 6'd7);
    pulse(1, 0, 0);
    repeat (15) @(negedge clk);
    checks++;
    if (editing !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got editing=%b expected 1 after 15 idle cycles", editing);
    end
    @(negedge clk);
    checks++;
    if (editing !== 1'b0 || time_ow !== 1'b0 || time_in !== hms(5'd5, 6'd6, 6'd7)) begin
      errors++;
      $display("FAIL timeout_expire: got ed=%b ow=%b t=%h expected 0/0/%h", editing, time_ow, time_in, hms(5'd5, 6'd6, 6'd7));
    end
    do_reset();
    pulse(1, 0, 0);
    repeat (14) @(negedge clk);
    btn_inc = 1;
    @(negedge clk);
    btn_inc = 0;
    checks++;
    if (time_in !== hms(5'd6, 6'd6, 6'd7) || editing !== 1'b1) begin
      errors++;
      $display("FAIL timeout_press15: got t=%h ed=%b expected %h/1", time_in, editing, hms(5'd6, 6'd6, 6'd7));
    end
    repeat (15) @(negedge clk);
    checks++;
    if (editing !== 1'b1) begin
      errors++;
      $display("FAIL timeout_restart: got editing=%b expected 1", editing);
    end
    @(negedge clk);
    checks++;
    if (editing !== 1'b0 || time_ow !== 1'b0) begin
      errors++;
      $display("FAIL timeout_restart_expire: got ed=%b ow=%b expected 0/0", editing, time_ow);
    end
  endtask

  task automatic test_reset_commit();
    int ow_n;
    do_reset();
    time_cur = hms(5'd9, 6'd8, 6'd7);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    sb.push_back(hms(5'd9, 6'd8, 6'd7));
    pulse(1, 0, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if (time_ow !== 1'b0 || time_in !== 17'd0 || editing !== 1'b0 || edit_field !== 2'd0) begin
      errors++;
      $display("FAIL reset_in_commit: got ow=%b t=%h ed=%b fld=%d expected 0/0/0/0", time_ow, time_in, editing, edit_field);
    end
    @(negedge clk);
    rst_n = 1;
    ow_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (time_ow) ow_n++;
    end
    checks++;
    if (ow_n != 0 || editing !== 1'b0) begin
      errors++;
      $display("FAIL reset_commit_aborted: got %0d ow cycles ed=%b expected 0/0", ow_n, editing);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_set();
    test_wrap();
    test_simultaneous();
    test_ignored();
    test_timeout();
    test_reset_commit();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending commits expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter OW_CYCLES, default 2, the number of cycles time_ow is held high per commit (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000, the number of consecutive no-button cycles in an edit state that aborts editing (legal range 2..2^20).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btn_mode, input, 1, one-cycle pulse, already debounced; enters or advances edit mode.
REQ-006 SHALL have port btn_inc, input, 1, one-cycle pulse; increments the selected field.
REQ-007 SHALL have port btn_dec, input, 1, one-cycle pulse; decrements the selected field.
REQ-008 SHALL have port time_cur, input, 17, the running time {hour[4:0], min[5:0], sec[5:0]} from the clock.
REQ-009 SHALL have port time_in, output, 17, the edit register {hour, min, sec}, driven continuously.
REQ-010 SHALL have port time_ow, output, 1, the overwrite strobe to the clock; high only in COMMIT.
REQ-011 SHALL have port editing, output, 1, high in EDIT_HR, EDIT_MIN and EDIT_SEC.
REQ-012 SHALL have port edit_field, output, 2, selected field: 0 none, 1 hour, 2 min, 3 sec.

Function
REQ-013 SHALL implement the states IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC and COMMIT.
REQ-014 IDLE + btn_mode SHALL capture time_cur into the edit register on that edge and enter EDIT_HR.
REQ-015 EDIT_HR, EDIT_MIN and EDIT_SEC + btn_mode SHALL advance to EDIT_MIN, EDIT_SEC and COMMIT respectively.
REQ-016 COMMIT SHALL hold time_ow=1 for exactly OW_CYCLES cycles, starting the cycle after the EDIT_SEC btn_mode edge, then return to IDLE with time_ow=0.
REQ-017 time_in SHALL be stable throughout COMMIT and for the cycle after it.
REQ-018 In an edit state, btn_inc SHALL set the selected field to field+1, or to 0 when field is at or above its max (hour 23, min/sec 59).
REQ-019 In an edit state, btn_dec SHALL set the selected field to max when field is 0 or above max, else to field-1.
REQ-020 Non-selected fields SHALL remain unchanged by btn_inc and btn_dec.
REQ-021 Precedence in one cycle SHALL be btn_mode over inc/dec: the transition is taken and the field is left unmodified.
REQ-022 btn_inc and btn_dec together without btn_mode SHALL be ignored.
REQ-023 All buttons SHALL be ignored in COMMIT, and btn_inc/btn_dec SHALL be ignored in IDLE.
REQ-024 The timeout counter SHALL clear on entry to any edit state and on every accepted button pulse.
REQ-025 After TIMEOUT_CYC consecutive edit-state cycles with no button pulse, the block SHALL enter IDLE on the next edge without asserting time_ow; time_in keeps its value.
REQ-026 In IDLE, editing=0 and edit_field=0; in COMMIT, editing=0 and edit_field=0.
REQ-027 The block SHALL not drive time_ow in IDLE or in any edit state.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, time_in=0, time_ow=0, editing=0, edit_field=0, all counters 0.
REQ-029 Reset asserted mid-edit or mid-COMMIT SHALL abort with no further time_ow cycles.
REQ-030 After rst_n deasserts, the first btn_mode SHALL be honored on the first rising edge.

Verification
REQ-031 Full set: time_cur=12:34:56, press mode, inc×2 on hour, mode, dec on min, mode, mode -> time_in=14:33:56, time_ow high exactly 2 cycles, then IDLE.
REQ-032 Wrap: hour 23 + inc -> 0; min 0 + dec -> 59; captured hour 30 + inc -> 0, + dec -> 23.
REQ-033 Simultaneous events: mode+inc in EDIT_MIN -> EDIT_SEC, min unchanged; inc+dec -> no change.
REQ-034 Timeout: TIMEOUT_CYC=16, enter EDIT_HR and idle 16 cycles -> IDLE, time_ow never high; a press at cycle 15 restarts the count.
REQ-035 Reset in COMMIT: rst_n low during the 1st time_ow cycle -> time_ow=0 at once, time_in=0, IDLE.
REQ-036 Ignored inputs: inc/dec in IDLE and any button in COMMIT -> no state or time_in change.
